// File: rtl/ibuf_mc_ctrl.sv
// Input-buffer controller for one router input port: FIFO of flits with multicast
// route masks, head presented to NPORT arbiters and retired once every destination is served.
module ibuf_mc_ctrl #(
  parameter  int PYLD_W = 23,
  parameter  int NPORT  = 5,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [NPORT-1:0]  in_route,
  input  logic [PYLD_W-1:0] in_pyld,
  input  logic              pg_en,
  output logic [NPORT-1:0]  arb_req,
  input  logic [NPORT-1:0]  arb_gnt,
  input  logic [NPORT-1:0]  obuf_rdy,
  output logic [PYLD_W-1:0] out_pyld,
  output logic [CNT_W-1:0]  occ,
  output logic              err_zero_route
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = NPORT + PYLD_W;

  logic [ENT_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  rd_nxt_s;
  logic              hs_s;
  logic              push_s;
  logic              zero_s;
  logic              pop_s;
  logic [NPORT-1:0]  served_s;
  logic [NPORT-1:0]  rem_s;
  logic [CNT_W-1:0]  occ_next_s;

  // Handshake decode, per-destination service and next occupancy
  always_comb begin
    hs_s       = in_vld & in_rdy;
    push_s     = hs_s & (|in_route);
    zero_s     = hs_s & ~(|in_route);
    served_s   = arb_req & arb_gnt & obuf_rdy;
    rem_s      = arb_req & ~served_s;
    pop_s      = (occ != {CNT_W{1'b0}}) & (rem_s == {NPORT{1'b0}}) &
                 (arb_req != {NPORT{1'b0}});
    occ_next_s = occ + CNT_W'(push_s) - CNT_W'(pop_s);
    rd_nxt_s   = rd_ptr_r + PTR_W'(1'b1);
  end

  // Storage array; the head entry stays in memory until popped
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_route, in_pyld};
    end
  end

  // Pointers, occupancy, upstream ready and zero-route pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r       <= {PTR_W{1'b0}};
      rd_ptr_r       <= {PTR_W{1'b0}};
      occ            <= {CNT_W{1'b0}};
      in_rdy         <= 1'b0;
      err_zero_route <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_nxt_s;
      occ            <= occ_next_s;
      // Registered from occ_next so a full buffer can never be overrun
      in_rdy         <= ~pg_en & (occ_next_s < CNT_W'(DEPTH));
      err_zero_route <= zero_s;
    end
  end

  // Head registers: remaining destinations and payload of the oldest flit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_req  <= {NPORT{1'b0}};
      out_pyld <= {PYLD_W{1'b0}};
    end else if (pop_s) begin
      // Next stored entry has priority; a same-cycle push only refills an emptied buffer
      if (occ > CNT_W'(1)) begin
        {arb_req, out_pyld} <= mem_r[rd_nxt_s];
      end else if (push_s) begin
        {arb_req, out_pyld} <= {in_route, in_pyld};
      end else begin
        arb_req <= {NPORT{1'b0}};
      end
    end else if (push_s && (occ == {CNT_W{1'b0}})) begin
      {arb_req, out_pyld} <= {in_route, in_pyld};
    end else begin
      arb_req <= rem_s;
    end
  end

endmodule

// File: tb/tb_ibuf_mc_ctrl.sv
// Table-driven bench for ibuf_mc_ctrl with a payload scoreboard checked at every head pop.
module tb_ibuf_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic [4:0]  in_route;
  logic [22:0] in_pyld;
  logic        pg_en;
  logic [4:0]  arb_req;
  logic [4:0]  arb_gnt;
  logic [4:0]  obuf_rdy;
  logic [22:0] out_pyld;
  logic [2:0]  occ;
  logic        err_zero_route;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        vld;
    logic [4:0]  route;
    logic [22:0] pyld;
    logic        pg;
    logic [4:0]  gnt;
    logic [4:0]  ordy;
    logic [4:0]  e_req;
    logic [22:0] e_pyld;
    logic [2:0]  e_occ;
    logic        e_rdy;
    logic        e_err;
  } vec_t;

  vec_t        vecs[$];
  logic [22:0] sb_q[$];

  ibuf_mc_ctrl #(.PYLD_W(23), .NPORT(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_route(in_route), .in_pyld(in_pyld), .pg_en(pg_en),
    .arb_req(arb_req), .arb_gnt(arb_gnt), .obuf_rdy(obuf_rdy),
    .out_pyld(out_pyld), .occ(occ), .err_zero_route(err_zero_route)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic vld, input logic [4:0] route, input logic [22:0] pyld,
                              input logic pg, input logic [4:0] gnt, input logic [4:0] ordy,
                              input logic [4:0] e_req, input logic [22:0] e_pyld,
                              input logic [2:0] e_occ, input logic e_rdy, input logic e_err);
    vec_t v;
    v.vld = vld; v.route = route; v.pyld = pyld; v.pg = pg; v.gnt = gnt; v.ordy = ordy;
    v.e_req = e_req; v.e_pyld = e_pyld; v.e_occ = e_occ; v.e_rdy = e_rdy; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input int idx, input logic [4:0] e_req, input logic [22:0] e_pyld,
                           input logic [2:0] e_occ, input logic e_rdy, input logic e_err);
    check($sformatf("row%0d arb_req", idx), 32'(arb_req), 32'(e_req));
    check($sformatf("row%0d out_pyld", idx), 32'(out_pyld), 32'(e_pyld));
    check($sformatf("row%0d occ", idx), 32'(occ), 32'(e_occ));
    check($sformatf("row%0d in_rdy", idx), 32'(in_rdy), 32'(e_rdy));
    check($sformatf("row%0d err_zero_route", idx), 32'(err_zero_route), 32'(e_err));
  endtask

  // Drive one row, update the scoreboard before the edge, check outputs after it
  task automatic apply(input int idx, input vec_t v);
    logic [22:0] exp_p;
    in_vld = v.vld; in_route = v.route; in_pyld = v.pyld;
    pg_en = v.pg; arb_gnt = v.gnt; obuf_rdy = v.ordy;
    #1;
    if ((arb_req != 5'h00) && ((arb_req & ~(arb_gnt & obuf_rdy)) == 5'h00)) begin
      if (sb_q.size() == 0) begin
        check($sformatf("row%0d sb_underflow", idx), 32'(1), 32'(0));
      end else begin
        exp_p = sb_q.pop_front();
        check($sformatf("row%0d sb_pop_pyld", idx), 32'(out_pyld), 32'(exp_p));
      end
    end
    if (in_vld && in_rdy && (in_route != 5'h00)) sb_q.push_back(in_pyld);
    @(posedge clk);
    #1;
    check_all(idx, v.e_req, v.e_pyld, v.e_occ, v.e_rdy, v.e_err);
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_route = 5'h00; in_pyld = 23'h0;
    pg_en = 1'b0; arb_gnt = 5'h00; obuf_rdy = 5'h00;

    //          vld   route  pyld      pg    gnt    ordy   e_req  e_pyld    occ   rdy   err
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h1F, 5'h1F, 5'h00, 23'h000, 3'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'h04, 23'h123, 1'b0, 5'h1F, 5'h1F, 5'h04, 23'h123, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h1F, 5'h1F, 5'h00, 23'h123, 3'd0, 1'b1, 1'b0));
    // partial multicast 0x13
    vecs.push_back(mk(1'b1, 5'h13, 23'h0AB, 1'b0, 5'h01, 5'h1F, 5'h13, 23'h0AB, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h01, 5'h1F, 5'h12, 23'h0AB, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h02, 5'h1F, 5'h10, 23'h0AB, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h10, 5'h1F, 5'h00, 23'h0AB, 3'd0, 1'b1, 1'b0));
    // grant without output-buffer ready
    vecs.push_back(mk(1'b1, 5'h08, 23'h3C5, 1'b0, 5'h08, 5'h00, 5'h08, 23'h3C5, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h08, 5'h00, 5'h08, 23'h3C5, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h08, 5'h08, 5'h00, 23'h3C5, 3'd0, 1'b1, 1'b0));
    // zero route behind a live head
    vecs.push_back(mk(1'b1, 5'h02, 23'h111, 1'b0, 5'h00, 5'h1F, 5'h02, 23'h111, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'h00, 23'h777, 1'b0, 5'h00, 5'h1F, 5'h02, 23'h111, 3'd1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h00, 5'h1F, 5'h02, 23'h111, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h02, 5'h1F, 5'h00, 23'h111, 3'd0, 1'b1, 1'b0));
    // fill to DEPTH, fifth flit held upstream, then drain across the wrap
    vecs.push_back(mk(1'b1, 5'h01, 23'h201, 1'b0, 5'h00, 5'h1F, 5'h01, 23'h201, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'h02, 23'h202, 1'b0, 5'h00, 5'h1F, 5'h01, 23'h201, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'h04, 23'h203, 1'b0, 5'h00, 5'h1F, 5'h01, 23'h201, 3'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'h08, 23'h204, 1'b0, 5'h00, 5'h1F, 5'h01, 23'h201, 3'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'h10, 23'h205, 1'b0, 5'h00, 5'h1F, 5'h01, 23'h201, 3'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'h10, 23'h205, 1'b0, 5'h01, 5'h1F, 5'h02, 23'h202, 3'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'h10, 23'h205, 1'b0, 5'h00, 5'h1F, 5'h02, 23'h202, 3'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h02, 5'h1F, 5'h04, 23'h203, 3'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h04, 5'h1F, 5'h08, 23'h204, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h08, 5'h1F, 5'h10, 23'h205, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h10, 5'h1F, 5'h00, 23'h205, 3'd0, 1'b1, 1'b0));
    // push and pop in the same cycle on a single-entry buffer
    vecs.push_back(mk(1'b1, 5'h01, 23'h301, 1'b0, 5'h1F, 5'h1F, 5'h01, 23'h301, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'h02, 23'h302, 1'b0, 5'h1F, 5'h1F, 5'h02, 23'h302, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b0, 5'h1F, 5'h1F, 5'h00, 23'h302, 3'd0, 1'b1, 1'b0));
    // power-gate with two flits stored: stop accepting, keep draining
    vecs.push_back(mk(1'b1, 5'h01, 23'h401, 1'b0, 5'h00, 5'h1F, 5'h01, 23'h401, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'h02, 23'h402, 1'b0, 5'h00, 5'h1F, 5'h01, 23'h401, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'h00, 23'h000, 1'b1, 5'h00, 5'h1F, 5'h01, 23'h401, 3'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'h04, 23'h4FF, 1'b1, 5'h01, 5'h1F, 5'h02, 23'h402, 3'd1, 1'b0, 1'b0));

    // reset values while held in reset
    #12;
    check_all(-1, 5'h00, 23'h000, 3'd0, 1'b0, 1'b0);
    #5 rst_n = 1'b1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // asynchronous reset in the middle of the drain clears everything at once
    #2 rst_n = 1'b0;
    #1;
    check_all(100, 5'h00, 23'h000, 3'd0, 1'b0, 1'b0);
    sb_q.delete();
    in_vld = 1'b0; pg_en = 1'b0; arb_gnt = 5'h00;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all(101, 5'h00, 23'h000, 3'd0, 1'b1, 1'b0);
    check("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibuf_mc_ctrl.md
# ibuf_mc_ctrl

Parametrised input-buffer controller for one router input port of the mesh node. It stores up to DEPTH flits with their multicast route masks and presents the head flit to NPORT output arbiters. It clears each destination request individually as that output grants and accepts, and releases the head only when every requested destination has been served. It sits between the link receiver and the per-output arbiters/output buffers.

## Interface
- PYLD_W, 23, payload width in bits
- NPORT, 5, number of output directions (bit 0 N, 1 W, 2 S, 3 E, 4 local)
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), occupancy width (derived, not overridden)

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_vld  in  1  upstream flit valid
- in_rdy  out  1  buffer can accept (registered)
- in_route  in  NPORT  destination mask of incoming flit (multicast allowed)
- in_pyld  in  PYLD_W  incoming payload
- pg_en  in  1  power-gate request: stop accepting, keep draining
- arb_req  out  NPORT  remaining destinations of head flit (registered)
- arb_gnt  in  NPORT  per-output grant from arbiters
- obuf_rdy  in  NPORT  per-output buffer ready
- out_pyld  out  PYLD_W  head payload (registered, stable until pop)
- occ  out  CNT_W  entries held, head included
- err_zero_route  out  1  one-cycle pulse: accepted handshake carried all-zero route

## Operation
- Reset: arb_req=0, out_pyld=0, occ=0, in_rdy=0, err_zero_route=0, pointers=0.
- Accept = in_vld & in_rdy. If |in_route, write {in_route,in_pyld} and occ+1. If in_route==0, discard, pulse err_zero_route next cycle, occ unchanged.
- served = arb_req & arb_gnt & obuf_rdy. rem_next = arb_req & ~served. Grant bits outside arb_req are ignored; a grant without obuf_rdy clears nothing.
- Pop when occ≠0 and rem_next==0 and arb_req≠0 (last destination served). On pop, the next stored entry (or, if none, the flit written this cycle) loads arb_req/out_pyld at the same edge; otherwise arb_req←0.
- Partial multicast: unserved bits stay set and out_pyld holds; no reordering, no drop.
- in_rdy <= ~pg_en & (occ_next < DEPTH), where occ_next includes this cycle's push and pop.
- pg_en=1: in_rdy falls next cycle. Stored flits continue to request and drain. No flush.
- Pointers wrap modulo DEPTH. occ never exceeds DEPTH. Overflow is impossible because in_rdy is registered from occ_next.

## Timing
- Push into empty buffer at edge T: arb_req/out_pyld valid after T. Earliest pop at T+1.
- Unicast or fully-granted multicast with continuous grants: one flit per cycle throughput.
- Simultaneous push and pop: occ unchanged. Pushed flit queues behind existing entries.
- Full (occ=DEPTH): in_rdy=0. A pop at edge T sets in_rdy=1 after T.
- First cycle after reset release: in_rdy rises at the first edge if pg_en=0.
- Reset asserted mid-operation: all state is cleared asynchronously and stored flits are lost.

## Test plan
- Reset then pg_en=0, arb_gnt=obuf_rdy=0x1F: push route 0x04 payload 0x123 -> arb_req=0x04, out_pyld=0x123 one cycle later; popped the next cycle, occ back to 0.
- Push route 0x13 with arb_gnt=0x01 then 0x02 then 0x10, obuf_rdy=0x1F -> arb_req steps 0x13→0x12→0x10→0x00; out_pyld stable throughout; single pop.
- arb_gnt=0x08 with obuf_rdy=0x00 on head route 0x08 -> arb_req stays 0x08; raise obuf_rdy bit 3 -> pop.
- DEPTH=4, no grants, push 5 flits back-to-back -> in_rdy drops after occ reaches 4, 5th held upstream; grant once -> in_rdy=1 next cycle, FIFO order preserved across wrap.
- Push route 0x00 -> err_zero_route pulse for 1 cycle, occ unchanged, arb_req unchanged.
- 2 flits stored, pg_en=1 -> in_rdy=0 next cycle, both flits still drain with grants. Assert rst_n=0 mid-drain -> all outputs 0 immediately.
